// File: rtl/spc_pkg.sv
// ============================================================================
//  Module   : spc_pkg
//  Purpose  : Shared constants and helpers for the SPC mailbox tracker.
//             - Default parameter values for the tracker.
//             - win_base(): word address of a channel's mailbox window.
//             - Field positions inside the SPC-readable status word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spc_pkg;

  localparam int              DEF_NUM_IP    = 5;
  localparam int              DEF_ADDR_W    = 32;
  localparam longint unsigned DEF_BASE_ADDR = 64'd48;
  localparam int              DEF_WIN_DEPTH = 16;

  // Status word: fresh flags sit at the bottom and the ovf flags follow
  // immediately after them. All bits above that read as zero.
  localparam int STATUS_W         = 32;
  localparam int STATUS_FRESH_LSB = 0;

  function automatic int status_ovf_lsb(input int num_ip);
    return STATUS_FRESH_LSB + num_ip;
  endfunction

  // Base word address of mailbox window idx.
  function automatic longint unsigned win_base(input longint unsigned base,
                                               input longint unsigned depth,
                                               input longint unsigned idx);
    return base + idx * depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spc_mbox_chan.sv
// ============================================================================
//  Module   : spc_mbox_chan
//  Purpose  : One mailbox channel. Tracks the write and read pointers of a
//             single window, the number of unread words and a sticky
//             overflow flag.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             wr            IP write strobe (one word per cycle)
//             rd, addr      SPC read enable and read address
//             ovf_clr       clear pulse for the overflow flag
//             wr_ptr        next address the IP writes
//             rd_ptr        oldest unread address
//             fresh         at least one unread word held
//             ovf           sticky: an unread word was overwritten
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spc_mbox_chan
  import spc_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                DEPTH  = DEF_WIN_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              fresh,
  output logic              ovf
);

  localparam int                PEND_W = $clog2(DEPTH + 1);
  localparam logic [PEND_W-1:0] FULL   = PEND_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = BASE + ADDR_W'(DEPTH - 1);
  // Window bounds are compared one bit wider so a window ending exactly at
  // the top of the address space does not wrap the upper bound to zero.
  localparam logic [ADDR_W:0]   LO     = {1'b0, BASE};
  localparam logic [ADDR_W:0]   HI     = {1'b0, BASE} + (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic hit, empty, full, rd_eff, rd_adv, ovf_set;

  function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? BASE : p + ADDR_W'(1);
  endfunction

  always_comb begin
    hit     = rd && ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    empty   = (pend_q == '0);
    full    = (pend_q == FULL);
    // A read of an empty window is an underflow and has no effect.
    rd_eff  = hit && !empty;
    // A write into a full window with no matching read drops the oldest word.
    ovf_set = wr && full && !rd_eff;
    rd_adv  = rd_eff || ovf_set;

    wr_ptr_d = wr     ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_adv ? nxt(rd_ptr_q) : rd_ptr_q;

    pend_d = pend_q;
    if (wr && !rd_adv) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!wr && rd_eff) begin
      pend_d = pend_q - PEND_W'(1);
    end

    // Set has priority over a simultaneous clear.
    ovf_d = ovf_set || (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= BASE;
      rd_ptr_q <= BASE;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign fresh  = !empty;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: rtl/spc_mbox_tracker.sv
// ============================================================================
//  Module   : spc_mbox_tracker
//  Purpose  : Per-IP mailbox tracker for the security policy controller.
//             One channel per IP window; derives fresh / overflow flags, an
//             SPC-readable status word and a maskable interrupt.
//  Ports    : PHI1, MASRST  clock / synchronous active-high reset
//             ip_wr         per-IP write strobes
//             spc_rd        SPC data read enable
//             spc_addr      SPC data read address
//             irq_mask      1 = suppress fresh-driven irq for a channel
//             ovf_clr       per-channel overflow clear pulses
//             wr_ptr/rd_ptr packed per-channel pointers, channel i at
//                           [i*ADDR_W +: ADDR_W]
//             fresh, ovf    per-channel flags
//             status        {0.., ovf, fresh}
//             irq           |(fresh & ~irq_mask) | |ovf
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spc_mbox_tracker
  import spc_pkg::*;
#(
  parameter int              NUM_IP    = DEF_NUM_IP,
  parameter int              ADDR_W    = DEF_ADDR_W,
  parameter longint unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int              WIN_DEPTH = DEF_WIN_DEPTH
) (
  input  logic                     PHI1,
  input  logic                     MASRST,
  input  logic [NUM_IP-1:0]        ip_wr,
  input  logic                     spc_rd,
  input  logic [ADDR_W-1:0]        spc_addr,
  input  logic [NUM_IP-1:0]        irq_mask,
  input  logic [NUM_IP-1:0]        ovf_clr,
  output logic [NUM_IP*ADDR_W-1:0] wr_ptr,
  output logic [NUM_IP*ADDR_W-1:0] rd_ptr,
  output logic [NUM_IP-1:0]        fresh,
  output logic [NUM_IP-1:0]        ovf,
  output logic [STATUS_W-1:0]      status,
  output logic                     irq
);

  localparam int OVF_LSB = status_ovf_lsb(NUM_IP);

  for (genvar i = 0; i < NUM_IP; i++) begin : g_chan
    spc_mbox_chan #(
      .ADDR_W (ADDR_W),
      .BASE   (ADDR_W'(win_base(BASE_ADDR, 64'(WIN_DEPTH), 64'(i)))),
      .DEPTH  (WIN_DEPTH)
    ) u_chan (
      .clk     (PHI1),
      .rst     (MASRST),
      .wr      (ip_wr[i]),
      .rd      (spc_rd),
      .addr    (spc_addr),
      .ovf_clr (ovf_clr[i]),
      .wr_ptr  (wr_ptr[i*ADDR_W +: ADDR_W]),
      .rd_ptr  (rd_ptr[i*ADDR_W +: ADDR_W]),
      .fresh   (fresh[i]),
      .ovf     (ovf[i])
    );
  end

  always_comb begin
    status = '0;
    status[STATUS_FRESH_LSB +: NUM_IP] = fresh;
    status[OVF_LSB +: NUM_IP]          = ovf;
  end

  // Overflow is never maskable; only the fresh contribution is.
  assign irq = (|(fresh & ~irq_mask)) || (|ovf);

endmodule

`default_nettype wire

// File: doc/spc_mbox_tracker.md
# spc_mbox_tracker

Parametrised per-IP mailbox tracker for the security policy controller (SPC). It watches NUM_IP fixed-size mailbox windows in SPC data memory and keeps a write pointer and a read pointer per window. From those it derives fresh-data flags, sticky overflow flags and a maskable interrupt, so the DLX no longer has to poll every window. It replaces the hard-coded five-window fresh-flag and address-counter logic with one generic channel per IP, adding occupancy counting, overflow detection and interrupt generation.

## Interface
- NUM_IP, 5: number of IP mailbox channels, 1..16
- ADDR_W, 32: address width
- BASE_ADDR, 48: word address of channel 0 window
- WIN_DEPTH, 16: words per window; power of two, at least 2; BASE_ADDR + NUM_IP*WIN_DEPTH ≤ 2^ADDR_W
- PHI1  in  1  clock. One clock; every flop is updated on the rising edge of PHI1.
- MASRST  in  1  reset. Synchronous and active-high; it overrides all other inputs.
- ip_wr  in  NUM_IP  per-IP write strobe, one word written per cycle asserted
- spc_rd  in  1  SPC data read enable
- spc_addr  in  ADDR_W  SPC data read address
- irq_mask  in  NUM_IP  1 = suppress fresh-driven irq for that channel
- ovf_clr  in  NUM_IP  per-channel overflow clear pulse
- wr_ptr  out  NUM_IP*ADDR_W  next address the IP writes; channel i at bits [i*ADDR_W +: ADDR_W]
- rd_ptr  out  NUM_IP*ADDR_W  oldest unread address per channel
- fresh  out  NUM_IP  channel holds at least one unread word
- ovf  out  NUM_IP  sticky: an unread word was overwritten
- status  out  32  bits [NUM_IP-1:0] = fresh, bits [2*NUM_IP-1:NUM_IP] = ovf, remaining bits 0; SPC-readable word
- irq  out  1  OR over channels of (fresh & ~irq_mask), OR-ed with any ovf

## Operation
- Window base for channel i: Bi = BASE_ADDR + i*WIN_DEPTH. Channel i owns addresses Bi .. Bi+WIN_DEPTH-1.
- Read hit for channel i: spc_rd=1 and spc_addr lies inside window i. The exact address is not checked against rd_ptr. Any address outside every window is ignored.
- Per-channel occupancy pend: range 0..WIN_DEPTH, width $clog2(WIN_DEPTH+1).
- Pointer advance: ptr+1. When ptr = Bi+WIN_DEPTH-1 it wraps to Bi.
- Write only:
  - pend < WIN_DEPTH: wr_ptr advances, pend+1.
  - pend = WIN_DEPTH: wr_ptr and rd_ptr both advance (oldest word is lost), pend stays WIN_DEPTH, ovf set.
- Read only:
  - pend > 0: rd_ptr advances, pend-1.
  - pend = 0: no change and no error; this is an underflow read.
- Write and read in the same cycle:
  - pend > 0 (full included): both pointers advance, pend unchanged, no ovf.
  - pend = 0: behaves as write only.
- fresh = (pend != 0).
- ovf_clr[i] clears ovf[i]. If ovf_clr[i] and an overflow happen in the same cycle, set wins.
- Reset values:
  - wr_ptr = rd_ptr = Bi, pend = 0
  - fresh = 0, ovf = 0, status = 0, irq = 0

## Timing
- The pointers, pend and ovf are registered and show the effect of a strobe one cycle after that strobe is sampled.
- fresh, status and irq are combinational decodes of those registers. They add no further latency and change in the same cycle as the pointers.
- irq_mask acts combinationally on irq.
- MASRST asserted mid-operation: at the next edge every channel returns to its reset state. Strobes presented in the reset cycle are discarded.
- No handshake is involved. ip_wr may stay high on consecutive cycles (one word per cycle); spc_rd likewise.

## Structure
- Package spc_pkg holds:
  - default parameter constants
  - function win_base(i) returning Bi
  - status-word field positions
- Sub-module spc_mbox_chan holds one channel: pointers, pend, ovf.
  - It takes base address and depth as parameters.
  - The top instantiates it NUM_IP times in a generate loop, then builds status and irq.

## Test plan
- Defaults, MASRST high for 1 cycle → wr_ptr[4]=112, rd_ptr[2]=80, fresh=0, status=0, irq=0.
- ip_wr[0] for one cycle → next cycle wr_ptr[0]=49, fresh[0]=1, irq=1. Then spc_rd with spc_addr=50 → rd_ptr[0]=49, fresh[0]=0, irq=0.
- ip_wr[1] held for 16 cycles → wr_ptr[1]=64 (wrapped), fresh[1]=1, ovf[1]=0. One more write → ovf[1]=1, status bit 6=1, rd_ptr[1]=65, irq=1 even with irq_mask=all ones.
- Channel 3 full, ip_wr[3] and spc_rd with spc_addr=100 in the same cycle → wr_ptr[3] and rd_ptr[3] each +1, ovf[3]=0.
- spc_rd with spc_addr=47, then 128 → no state change. spc_rd with spc_addr=85 while channel 2 is empty → rd_ptr[2] stays 80.
- Channel 0 full, ip_wr[0] and ovf_clr[0] in the same cycle → ovf[0]=1. Next cycle ovf_clr[0] alone → ovf[0]=0. MASRST asserted while channels are busy → all reset values next cycle.
